div_mod_top_level: RTL and testbench
====================================

Name: div_mod_top_level

Overview:
- Sequential signed integer divider/modulo unit: accepts a 32-bit signed dividend and a 16-bit signed divisor with a valid strobe.
- Produces either the quotient (mode=1) or the remainder (mode=0) as an 18-bit signed result with a one-cycle valid pulse.
- Standalone arithmetic block sitting behind a simple valid-in/valid-out handshake; one operation in flight at a time.

Parameters:
none (all widths fixed: dividend 32, divisor 16, result 18)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
dividend  input  32  signed two's-complement dividend
divisor  input  16  signed two's-complement divisor
mode  input  1  1 = output quotient, 0 = output remainder
valid_input  input  1  operands/mode valid; sampled only in IDLE
valid_output  output  1  one-cycle pulse when final_output holds a new result
final_output  output  18  signed two's-complement result

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, valid_output=0, final_output=0, iteration counter=0, all internal registers cleared. Reset mid-operation aborts the operation; no valid_output follows.
- States: IDLE, CALC, FIX, DONE.
- IDLE: on a rising edge with valid_input=1, register dividend, divisor and mode, plus the sign of each operand. Load magnitudes |dividend| (33-bit safe for -2^31) and |divisor| (17-bit safe for -2^15). Clear the counter and go to CALC. valid_input=0 means stay in IDLE.
- CALC: restoring division on magnitudes, one quotient bit per cycle, MSB first, over exactly 32 cycles. Each cycle: shift the partial remainder left and bring in the next dividend bit; if the partial remainder >= |divisor|, subtract it and set the quotient bit to 1. After the 32nd iteration, go to FIX.
- FIX (1 cycle): apply signs and select the output.
  - Quotient sign = sign(dividend) XOR sign(divisor); quotient truncates toward zero.
  - Remainder sign follows the dividend (C semantics), so dividend = quotient*divisor + remainder.
  - Quotient saturates to the 18-bit signed range: >131071 gives 131071 (18'h1FFFF); < -131072 gives -131072 (18'h20000).
  - Remainder always fits; sign-extend to 18 bits.
  - Register final_output, set valid_output=1, go to DONE.
- DONE (1 cycle): valid_output=0, go to IDLE.
- Latency: with the accepting edge as E0, valid_output is high between E33 and E34. The next operation can be accepted at E35 or later.
- final_output holds its value until the next FIX or reset.
- valid_input asserted outside IDLE is ignored (no queueing). Operand or mode changes after acceptance have no effect on the operation in flight.
- Divide by zero (divisor=0):
  - Quotient: 131071 if dividend >= 0, else -131072.
  - Remainder: 0.
  - Same latency and valid_output pulse as a normal operation.
- Overflow case -2^31 / -1: quotient saturates to 131071; remainder 0.
- Single clock domain. No combinational path from inputs to outputs.

Test Plan:
- Reset low 50 ns then high; dividend=80, divisor=10, mode=1, valid_input pulsed 1 cycle -> valid_output pulses once, 33 cycles after the accepting edge, with final_output=8; mode=0 with the same operands -> final_output=0.
- dividend=-7, divisor=2: mode=1 -> 18'h3FFFD (-3); mode=0 -> 18'h3FFFF (-1). dividend=7, divisor=-2: mode=1 -> -3; mode=0 -> 1.
- Saturation: dividend=32'h7FFFFFFF, divisor=1, mode=1 -> 18'h1FFFF. dividend=-2^31, divisor=1 -> 18'h20000. dividend=-2^31, divisor=-1 -> 18'h1FFFF. dividend=-2^31, divisor=-32768, mode=1 -> 65536.
- Divide by zero: dividend=100, divisor=0, mode=1 -> 18'h1FFFF; dividend=-5, divisor=0, mode=1 -> 18'h20000; mode=0 -> 0. valid_output still pulses at the normal latency.
- Handshake: hold valid_input high continuously with changing operands -> only IDLE-time operands are processed; exactly one valid_output per accepted operation; earliest re-accept is 35 cycles after the previous accept.
- Assert reset=0 at cycle 10 of CALC -> valid_output and final_output go to 0 immediately; no pulse follows. A new operation after release gives a correct result.

Source files
------------

// File: rtl/div_mod_top_level.sv
// Sequential signed divider/modulo: 32-bit dividend / 16-bit divisor, restoring
// division on magnitudes (one bit per cycle), 18-bit saturated signed result.
//
// state | meaning
// IDLE  | waiting for valid_input; captures operands, signs and magnitudes
// CALC  | 32 restoring-division iterations, quotient bit MSB first
// FIX   | apply signs, saturate quotient, register result, raise valid_output
// DONE  | drop valid_output, return to IDLE
module div_mod_top_level (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  input  logic        mode,
  input  logic        valid_input,
  output logic        valid_output,
  output logic [17:0] final_output
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] q;
  logic [15:0] rem;
  logic [15:0] dvs_mag;
  logic        sign_dvd;
  logic        sign_dvs;
  logic        mode_r;

  logic [31:0] dvd_mag_in;
  logic [15:0] dvs_mag_in;
  logic [16:0] rem_sh;
  logic        rem_ge;
  logic [15:0] rem_sub;
  logic        dvs_zero;
  logic        neg_q;
  logic [17:0] rem_ext;
  logic [17:0] quot_res;
  logic [17:0] rem_res;

  // Magnitudes as unsigned values, so -2^31 and -2^15 are representable
  always_comb begin
    dvd_mag_in = dividend[31] ? (~dividend + 32'd1) : dividend;
    dvs_mag_in = divisor[15] ? (~divisor + 16'd1) : divisor;
  end

  // Partial remainder stays below |divisor| <= 2^15, so 16 bits plus the shifted-in bit suffice
  always_comb begin
    rem_sh  = {rem, q[31]};
    rem_ge  = (rem_sh >= {1'b0, dvs_mag});
    rem_sub = 16'(rem_sh - {1'b0, dvs_mag});
  end

  always_comb begin
    dvs_zero = (dvs_mag == 16'd0);
    neg_q    = sign_dvd ^ sign_dvs;
    rem_ext  = {2'b00, rem};
    quot_res = 18'd0;
    rem_res  = 18'd0;
    if (dvs_zero) begin
      quot_res = sign_dvd ? 18'h20000 : 18'h1FFFF;
      rem_res  = 18'd0;
    end else begin
      if (!neg_q)
        quot_res = (q > 32'd131071) ? 18'h1FFFF : q[17:0];
      else
        quot_res = (q > 32'd131072) ? 18'h20000 : 18'(~q + 32'd1);
      rem_res = sign_dvd ? (~rem_ext + 18'd1) : rem_ext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      valid_output <= 1'b0;
      final_output <= 18'd0;
      cnt          <= 5'd0;
      q            <= 32'd0;
      rem          <= 16'd0;
      dvs_mag      <= 16'd0;
      sign_dvd     <= 1'b0;
      sign_dvs     <= 1'b0;
      mode_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_output <= 1'b0;
          if (valid_input) begin
            sign_dvd <= dividend[31];
            sign_dvs <= divisor[15];
            mode_r   <= mode;
            q        <= dvd_mag_in;
            dvs_mag  <= dvs_mag_in;
            rem      <= 16'd0;
            cnt      <= 5'd0;
            state    <= CALC;
          end
        end
        CALC: begin
          q   <= {q[30:0], rem_ge};
          rem <= rem_ge ? rem_sub : rem_sh[15:0];
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= FIX;
        end
        FIX: begin
          final_output <= mode_r ? quot_res : rem_res;
          valid_output <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          valid_output <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_mod_top_level.sv
// Bench for div_mod_top_level: directed table, random ops against an
// arithmetic reference model, continuous-valid handshake and mid-op reset.
module tb_div_mod_top_level;

  logic        clk;
  logic        reset;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        mode;
  logic        valid_input;
  logic        valid_output;
  logic [17:0] final_output;

  int vectors = 0;
  int miscompares = 0;

  div_mod_top_level dut (
    .clk          (clk),
    .reset        (reset),
    .dividend     (dividend),
    .divisor      (divisor),
    .mode         (mode),
    .valid_input  (valid_input),
    .valid_output (valid_output),
    .final_output (final_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic        m;
    logic [17:0] exp;
  } vec_t;

  function automatic logic [17:0] model(logic [31:0] a, logic [15:0] b, logic m);
    longint sa, sb, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      qv = (sa >= 0) ? 131071 : -131072;
      rv = 0;
    end else begin
      qv = sa / sb;
      rv = sa % sb;
      if (qv > 131071) qv = 131071;
      if (qv < -131072) qv = -131072;
    end
    return m ? 18'(qv) : 18'(rv);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Call at #1 after a rising edge with the DUT able to accept at the next edge.
  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input logic m,
                        input logic [17:0] exp, input string name);
    int lat;
    dividend    = a;
    divisor     = b;
    mode        = m;
    valid_input = 1'b1;
    @(posedge clk); #1;
    valid_input = 1'b0;
    dividend    = $urandom;
    divisor     = 16'($urandom);
    mode        = ~m;
    lat = 0;
    while (!valid_output && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd33);
    check({name, " result"}, {14'd0, final_output}, {14'd0, exp});
    @(posedge clk); #1;
    check({name, " pulse_width"}, {31'd0, valid_output}, 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] ops_a [0:104];
    logic [15:0] ops_b [0:104];
    logic        ops_m [0:104];
    int pulses;
    logic        exp_v;
    logic [31:0] ra;
    logic [15:0] rb;
    logic        rm;

    tbl.push_back('{32'd80,        16'd10,     1'b1, 18'd8});
    tbl.push_back('{32'd80,        16'd10,     1'b0, 18'd0});
    tbl.push_back('{-32'sd7,       16'd2,      1'b1, 18'h3FFFD});
    tbl.push_back('{-32'sd7,       16'd2,      1'b0, 18'h3FFFF});
    tbl.push_back('{32'd7,         -16'sd2,    1'b1, 18'h3FFFD});
    tbl.push_back('{32'd7,         -16'sd2,    1'b0, 18'd1});
    tbl.push_back('{32'h7FFFFFFF,  16'd1,      1'b1, 18'h1FFFF});
    tbl.push_back('{32'h80000000,  16'd1,      1'b1, 18'h20000});
    tbl.push_back('{32'h80000000,  16'hFFFF,   1'b1, 18'h1FFFF});
    tbl.push_back('{32'h80000000,  16'hFFFF,   1'b0, 18'd0});
    tbl.push_back('{32'h80000000,  16'h8000,   1'b1, 18'd65536});
    tbl.push_back('{32'd100,       16'd0,      1'b1, 18'h1FFFF});
    tbl.push_back('{-32'sd5,       16'd0,      1'b1, 18'h20000});
    tbl.push_back('{-32'sd5,       16'd0,      1'b0, 18'd0});
    tbl.push_back('{32'd1000003,   16'd1000,   1'b0, 18'd3});
    tbl.push_back('{-32'sd1000003, 16'd1000,   1'b0, 18'h3FFFD});
    tbl.push_back('{32'd131072,    -16'sd1,    1'b1, 18'h20000});
    tbl.push_back('{32'd131073,    -16'sd1,    1'b1, 18'h20000});

    reset       = 1'b0;
    dividend    = '0;
    divisor     = '0;
    mode        = 1'b0;
    valid_input = 1'b0;
    #50;
    check("reset valid_output", {31'd0, valid_output}, 32'd0);
    check("reset final_output", {14'd0, final_output}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].exp, $sformatf("table[%0d]", i));

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 16'($urandom);
        1: rb = 16'($urandom_range(1, 255));
        2: rb = -16'($urandom_range(1, 255));
        default: rb = 16'd0;
      endcase
      if (i % 4 == 1) ra = 32'($signed(ra) >>> 12);
      rm = 1'($urandom);
      run_op(ra, rb, rm, model(ra, rb, rm), $sformatf("random[%0d]", i));
    end

    // valid_input held high with operands changing every cycle
    pulses = 0;
    for (int c = 0; c < 105; c++) begin
      ops_a[c] = $urandom;
      ops_b[c] = 16'($urandom_range(1, 4000)) ^ (($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000);
      ops_m[c] = 1'($urandom);
      dividend    = ops_a[c];
      divisor     = ops_b[c];
      mode        = ops_m[c];
      valid_input = 1'b1;
      @(posedge clk); #1;
      exp_v = (c == 33 || c == 68 || c == 103);
      check($sformatf("stream valid c=%0d", c), {31'd0, valid_output}, {31'd0, exp_v});
      if (valid_output && c >= 33) begin
        pulses++;
        check($sformatf("stream result c=%0d", c), {14'd0, final_output},
              {14'd0, model(ops_a[c-33], ops_b[c-33], ops_m[c-33])});
      end
    end
    valid_input = 1'b0;
    check("stream pulse count", 32'(pulses), 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // reset asserted in the middle of CALC
    run_op(32'd5000, 16'd7, 1'b1, 18'd714, "pre-reset op");
    dividend    = 32'd999;
    divisor     = 16'd3;
    mode        = 1'b1;
    valid_input = 1'b1;
    @(posedge clk); #1;
    valid_input = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midreset valid_output", {31'd0, valid_output}, 32'd0);
    check("midreset final_output", {14'd0, final_output}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (valid_output) pulses++;
    end
    check("midreset no pulse", 32'(pulses), 32'd0);
    run_op(32'hFFFF0000, 16'd300, 1'b0, model(32'hFFFF0000, 16'd300, 1'b0), "post-reset rem");
    run_op(32'hFFFF0000, 16'd300, 1'b1, model(32'hFFFF0000, 16'd300, 1'b1), "post-reset quot");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
